// File: rtl/semaforo_input_cond_if.sv
// Sensor/button bundle between the pad side and the input conditioner.
// Latency: none, wires only.
// Backpressure: none; raw levels flow in, conditioned levels and pulses flow out.
interface semaforo_input_cond_if;
    // Raw, asynchronous pad levels
    logic ta_raw;
    logic tb_raw;
    logic p_raw;
    logic r_raw;
    // Conditioned outputs consumed by the traffic-light controller
    logic TA;
    logic TB;
    logic P;
    logic R;

    // Pad / stimulus side: drives raw levels, observes conditioned outputs
    modport master (
        output ta_raw,
        output tb_raw,
        output p_raw,
        output r_raw,
        input  TA,
        input  TB,
        input  P,
        input  R
    );

    // Conditioner side: consumes raw levels, drives conditioned outputs
    modport slave (
        input  ta_raw,
        input  tb_raw,
        input  p_raw,
        input  r_raw,
        output TA,
        output TB,
        output P,
        output R
    );
endinterface

// File: rtl/semaforo_input_cond.sv
// Synchronizes and debounces vehicle sensors and parade buttons; buttons become one-cycle pulses.
// Latency: a stable raw step sampled at edge k shows at the outputs at edge k+1+DEB_CYCLES.
// Backpressure: none; the controller consumes levels and pulses every cycle.
module semaforo_input_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int WIDTH      = 4
) (
    input logic             clk,
    input logic             rst,
    semaforo_input_cond_if.slave bus
);

    // Counter value at which a persistent difference is accepted as the new level.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(DEB_CYCLES - 1);

    // Channel order: 0 = avenue A, 1 = avenue B, 2 = parade, 3 = parade reset.
    localparam int NCH = 4;

    logic [NCH-1:0] raw_vec;
    logic [NCH-1:0] sync_q1;
    logic [NCH-1:0] sync_q2;
    logic [NCH-1:0] flip;

    assign raw_vec = {bus.r_raw, bus.p_raw, bus.tb_raw, bus.ta_raw};

    // Two-flop synchronizer on every raw pad input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_vec;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_deb
        logic [WIDTH-1:0] cnt;
        logic             lvl;

        // Count consecutive cycles the synchronized input disagrees with the level;
        // any agreement restarts the count, so short glitches never reach LAST.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync_q2[ch] == lvl) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                lvl <= sync_q2[ch];
                cnt <= '0;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end

        // High in the cycle whose closing edge flips the debounced level.
        assign flip[ch] = (sync_q2[ch] != lvl) && (cnt == LAST);
    end

    // A rising flip of the button level is the moment the pulse must appear,
    // so the pulse flop is loaded alongside the level flop.
    logic p_rise;
    logic r_rise;
    logic p_q;
    logic r_q;

    assign p_rise = flip[2] & sync_q2[2];
    assign r_rise = flip[3] & sync_q2[3];

    // Register button pulses; parade entry wins over parade reset on a tie.
    // The r level still updates on a tie, so that press can never pulse R later.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= 1'b0;
            r_q <= 1'b0;
        end else begin
            p_q <= p_rise;
            r_q <= r_rise & ~p_rise;
        end
    end

    assign bus.TA = g_deb[0].lvl;
    assign bus.TB = g_deb[1].lvl;
    assign bus.P  = p_q;
    assign bus.R  = r_q;

endmodule
